// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: constants and types shared by the memory controller files.
//   InstAddrBus / InstBus : address and instruction widths (32)
//   ZeroWord              : all-zero word used for reset values
//   state_e               : controller states
//   Width*                : mem_width codes (01 byte, 10 half, 11 word)
//   byte_count()          : bytes moved for a given mem_width code
package mem_ctrl_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] WidthByte = 2'b01;
  localparam logic [1:0] WidthHalf = 2'b10;
  localparam logic [1:0] WidthWord = 2'b11;

  // 00 is not a legal width; it is moved as one byte so a stray request
  // still completes instead of leaving the requester waiting forever.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      WidthHalf: byte_count = 3'd2;
      WidthWord: byte_count = 3'd4;
      default:   byte_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch-stage, MEM-stage and byte-RAM signals of the memory
// controller, bundled.
//   slave  : the controller's view (requests and ram_din in, results out)
//   master : the requester/RAM side view
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                   if_req;
  logic [InstAddrBus-1:0] if_addr;
  logic                   if_done;
  logic [InstBus-1:0]     if_inst;

  logic                   mem_req;
  logic                   mem_we;
  logic [1:0]             mem_width;
  logic [InstAddrBus-1:0] mem_addr;
  logic [InstBus-1:0]     mem_wdata;
  logic                   mem_done;
  logic [InstBus-1:0]     mem_rdata;

  logic [InstAddrBus-1:0] ram_addr;
  logic                   ram_wr;
  logic [7:0]             ram_dout;
  logic [7:0]             ram_din;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
           ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
           ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl_last_inst_buf.sv
// last_inst_buf: single-entry buffer of the most recent RAM instruction fetch.
// Only built when MEMCTRL_LAST_INST_EN is defined.
//   clk, rst     : clock, synchronous active-high reset (clears valid)
//   load         : capture (pc, inst) and mark valid
//   invalidate   : drop the entry (a store may have changed the code)
//   lookup_addr  : fetch address being considered
//   hit/hit_inst : entry valid and pc matches; buffered instruction
`ifdef MEMCTRL_LAST_INST_EN
module last_inst_buf
  import mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [InstAddrBus-1:0] pc,
  input  logic [InstBus-1:0]     inst,
  input  logic                   invalidate,
  input  logic [InstAddrBus-1:0] lookup_addr,
  output logic                   hit,
  output logic [InstBus-1:0]     hit_inst
);

  logic                   valid_q;
  logic [InstAddrBus-1:0] pc_q;
  logic [InstBus-1:0]     inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (invalidate) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pc_q   <= pc;
      inst_q <= inst;
    end
  end

  assign hit      = valid_q && (lookup_addr == pc_q);
  assign hit_inst = inst_q;

endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the
// MEM stage. Word fetches and 1/2/4-byte loads/stores are serialised into
// byte accesses; results come back with a one-cycle done pulse.
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global enable; low freezes every register
//   bus      : mem_ctrl_if.slave (fetch port, data port, RAM port)
// Optional: define MEMCTRL_LAST_INST_EN to add a last-fetch buffer that
// answers a repeated fetch of the same pc in one cycle without RAM traffic.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  logic [InstAddrBus-1:0] ram_addr_q;
  logic [InstAddrBus-1:0] base_q;
  logic [2:0]             cnt_q;
  logic [2:0]             iss_q;
  logic [2:0]             rcv_q;
  logic                   vld_p1;
  logic [InstBus-1:0]     data_buf;
  logic [InstBus-1:0]     wdata_q;
  logic [InstBus-1:0]     asm_word;
  logic [InstBus-1:0]     if_inst_q;
  logic [InstBus-1:0]     mem_rdata_q;
  logic                   if_done_q;
  logic                   mem_done_q;
  logic                   rd_state;

  logic acc_mem, acc_if, acc_hit, issue, capture, finish, wr_step;

  logic               lib_hit;
  logic [InstBus-1:0] lib_inst;

`ifdef MEMCTRL_LAST_INST_EN
  last_inst_buf u_last_inst_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (finish && (state_q == IF_RD)),
    .pc          (base_q),
    .inst        (asm_word),
    .invalidate  (acc_mem && bus.mem_we),
    .lookup_addr (bus.if_addr),
    .hit         (lib_hit),
    .hit_inst    (lib_inst)
  );
`else
  assign lib_hit  = 1'b0;
  assign lib_inst = ZeroWord;
`endif

  assign rd_state = (state_q == IF_RD) || (state_q == MEM_RD);

  // Current word with the byte now on ram_din dropped into lane rcv_q.
  always_comb begin
    asm_word = data_buf;
    asm_word[{rcv_q[1:0], 3'b000} +: 8] = bus.ram_din;
  end

  always_comb begin
    state_d = state_q;
    acc_mem = 1'b0;
    acc_if  = 1'b0;
    acc_hit = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    wr_step = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          // No arbitration while a done pulse is out: the requester still
          // holds its req in that cycle and must not be served twice.
          if (!(if_done_q || mem_done_q)) begin
            if (bus.mem_req) begin
              acc_mem = 1'b1;
              state_d = bus.mem_we ? MEM_WR : MEM_RD;
            end else if (bus.if_req) begin
              if (lib_hit) begin
                acc_hit = 1'b1;
              end else begin
                acc_if  = 1'b1;
                state_d = IF_RD;
              end
            end
          end
        end
        IF_RD, MEM_RD: begin
          issue   = (iss_q < cnt_q);
          capture = vld_p1;
          finish  = vld_p1 && (rcv_q == cnt_q - 3'd1);
          if (finish) state_d = IDLE;
        end
        MEM_WR: begin
          wr_step = 1'b1;
          finish  = (iss_q == cnt_q - 3'd1);
          if (finish) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: address issue, byte capture, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= ZeroWord;
      cnt_q       <= 3'd0;
      iss_q       <= 3'd0;
      rcv_q       <= 3'd0;
      vld_p1      <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else if (rdy) begin
      state_q    <= state_d;
      if_done_q  <= acc_hit || (finish && (state_q == IF_RD));
      mem_done_q <= finish && (state_q != IF_RD);
      if (acc_mem || acc_if) begin
        ram_addr_q <= acc_mem ? bus.mem_addr : bus.if_addr;
        cnt_q      <= acc_mem ? byte_count(bus.mem_width) : 3'd4;
        iss_q      <= 3'd0;
        rcv_q      <= 3'd0;
        vld_p1     <= 1'b0;
      end
      if (rd_state) vld_p1 <= issue;
      // The address stays on the last byte once all bytes are issued.
      if (issue || wr_step) begin
        iss_q <= iss_q + 3'd1;
        if ((iss_q + 3'd1) < cnt_q) ram_addr_q <= ram_addr_q + 32'd1;
      end
      if (capture) rcv_q <= rcv_q + 3'd1;
      if (acc_hit) if_inst_q <= lib_inst;
      if (finish && (state_q == IF_RD))  if_inst_q   <= asm_word;
      if (finish && (state_q == MEM_RD)) mem_rdata_q <= asm_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (acc_mem || acc_if) begin
        base_q   <= acc_mem ? bus.mem_addr : bus.if_addr;
        data_buf <= ZeroWord;
      end
      if (acc_mem) wdata_q <= bus.mem_wdata;
      if (capture) data_buf <= asm_word;
    end
  end

  // While frozen with a byte in flight, point the RAM back at that byte so
  // the value on ram_din when rdy returns is the one still to be captured.
  assign bus.ram_addr  = (!rdy && vld_p1) ? (base_q + InstAddrBus'(rcv_q))
                                          : ram_addr_q;
  assign bus.ram_wr    = rdy && (state_q == MEM_WR);
  assign bus.ram_dout  = wdata_q[{iss_q[1:0], 3'b000} +: 8];
  assign bus.if_done   = rdy && if_done_q;
  assign bus.mem_done  = rdy && mem_done_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 1 KiB byte RAM model
// (registered read, indexed by ram_addr[9:0]).
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  logic [7:0] ram [0:1023];

  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_addr[9:0]];
    if (bus.ram_wr) ram[bus.ram_addr[9:0]] <= bus.ram_dout;
  end

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] log_addr [0:63];
  logic        log_wr   [0:63];
  logic [7:0]  log_dout [0:63];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic fetch, input logic we,
                         input logic [1:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    @(negedge clk);
    if (fetch) begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end else begin
      bus.mem_we    = we;
      bus.mem_width = width;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_req   = 1'b1;
    end
    lat  = -1;
    data = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      log_addr[k] = bus.ram_addr;
      log_wr[k]   = bus.ram_wr;
      log_dout[k] = bus.ram_dout;
      if (fetch ? bus.if_done : bus.mem_done) begin
        lat  = k;
        data = fetch ? bus.if_inst : bus.mem_rdata;
        break;
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, km, ki, cnt;
    logic [31:0] d, dm, di, a, w, prev;

    // kind, we, width, addr, wdata, expected data, expected done cycle
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0, 32'h00A0_0513, 6};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'h0000_BEEF, 32'h0, 3};
    vecs[2]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0020, 32'h0, 32'h0000_BEEF, 6};
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0040, 32'h0, 32'h4433_2211, 6};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0042, 32'h0, 32'h0000_4433, 4};
    vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0043, 32'h0, 32'h0000_0044, 3};
    vecs[6]  = '{1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA, 6};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0030, 32'h1234_5678, 32'h0, 2};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0030, 32'h0, 32'h0000_0078, 4};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 32'h0000_0050, 32'hCAFE_F00D, 32'h0, 5};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 6};
    vecs[11] = '{1'b1, 1'b0, 2'b11, 32'h0000_0104, 32'h0, 32'h0010_0893, 6};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'hA0; ram[10'h103] = 8'h00;
    ram[10'h104] = 8'h93; ram[10'h105] = 8'h08; ram[10'h106] = 8'h10; ram[10'h107] = 8'h00;
    ram[10'h040] = 8'h11; ram[10'h041] = 8'h22; ram[10'h042] = 8'h33; ram[10'h043] = 8'h44;
    ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB; ram[10'h000] = 8'hCC; ram[10'h001] = 8'hDD;

    rst           = 1'b1;
    rdy           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_width = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    repeat (3) @(negedge clk);
    check("reset if_done",   {31'b0, bus.if_done},  32'h0);
    check("reset mem_done",  {31'b0, bus.mem_done}, 32'h0);
    check("reset ram_wr",    {31'b0, bus.ram_wr},   32'h0);
    check("reset ram_addr",  bus.ram_addr,  32'h0);
    check("reset if_inst",   bus.if_inst,   32'h0);
    check("reset mem_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;

    // Table of single transactions.
    for (int v = 0; v < 12; v++) begin
      run_txn(vecs[v].fetch, vecs[v].we, vecs[v].width, vecs[v].addr,
              vecs[v].wdata, lat, d);
      check($sformatf("vec%0d latency", v), lat, vecs[v].exp_lat);
      if (!vecs[v].we) check($sformatf("vec%0d data", v), d, vecs[v].exp_data);
      n = vecs[v].fetch ? 4 : ((vecs[v].width == 2'b11) ? 4 : int'(vecs[v].width));
      w = vecs[v].wdata;
      for (int i = 0; i < n; i++) begin
        a = vecs[v].addr + i;
        check($sformatf("vec%0d ram_addr[%0d]", v, i), log_addr[i+1], a);
        if (vecs[v].we) begin
          check($sformatf("vec%0d ram_wr[%0d]", v, i), {31'b0, log_wr[i+1]}, 32'h1);
          check($sformatf("vec%0d ram_dout[%0d]", v, i), {24'b0, log_dout[i+1]},
                {24'b0, w[7:0]});
          check($sformatf("vec%0d ram byte[%0d]", v, i), {24'b0, ram[a[9:0]]},
                {24'b0, w[7:0]});
          w = w >> 8;
        end
      end
      if (vecs[v].we) begin
        a = vecs[v].addr + n;
        check($sformatf("vec%0d byte past end", v), {24'b0, ram[a[9:0]]}, 32'h0);
      end
    end

    // Simultaneous requests: byte load first, fetch after the dead cycle.
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_width = 2'b01; bus.mem_addr = 32'h43;
    bus.mem_req = 1'b1;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    km = -1; ki = -1; dm = '0; di = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.mem_done && km < 0) begin
        km = k; dm = bus.mem_rdata; bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        ki = k; di = bus.if_inst; bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    check("simul mem_done cycle", km, 3);
    check("simul mem_rdata",      dm, 32'h44);
    check("simul if_done cycle",  ki, 10);
    check("simul if_inst",        di, 32'h00A0_0513);

    // Word load with rdy low for two cycles.
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_width = 2'b11; bus.mem_addr = 32'h40;
    bus.mem_req = 1'b1;
    lat = -1; d = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.mem_done) begin
        lat = k; d = bus.mem_rdata;
        break;
      end
      if (k == 2) rdy = 1'b0;
      if (k == 4) rdy = 1'b1;
    end
    rdy = 1'b1;
    bus.mem_req = 1'b0;
    check("rdy-low done cycle", lat, 8);
    check("rdy-low data",       d,   32'h4433_2211);

    // Reset in the middle of a fetch.
    @(negedge clk);
    bus.if_addr = 32'h104; bus.if_req = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.if_done) cnt++;
    end
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    check("midrst if_inst",   bus.if_inst,   32'h0);
    check("midrst mem_rdata", bus.mem_rdata, 32'h0);
    check("midrst ram_addr",  bus.ram_addr,  32'h0);
    check("midrst ram_wr",    {31'b0, bus.ram_wr}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.if_done) cnt++;
    end
    check("midrst no if_done", cnt, 0);
    run_txn(1'b1, 1'b0, 2'b11, 32'h104, 32'h0, lat, d);
    check("post-reset fetch cycle", lat, 6);
    check("post-reset fetch inst",  d,   32'h0010_0893);

    // Repeat fetch of the same pc, then again after a store.
    prev = bus.ram_addr;
    run_txn(1'b1, 1'b0, 2'b11, 32'h104, 32'h0, lat, d);
`ifdef MEMCTRL_LAST_INST_EN
    check("repeat fetch cycle",    lat, 1);
    check("repeat fetch ram_addr", log_addr[1], prev);
`else
    check("repeat fetch cycle",    lat, 6);
    check("repeat fetch ram_addr", log_addr[1], 32'h104);
`endif
    check("repeat fetch inst", d, 32'h0010_0893);
    run_txn(1'b0, 1'b1, 2'b01, 32'h60, 32'h0000_00A5, lat, d);
    check("intervening store cycle", lat, 2);
    run_txn(1'b1, 1'b0, 2'b11, 32'h104, 32'h0, lat, d);
    check("fetch after store cycle",    lat, 6);
    check("fetch after store ram_addr", log_addr[1], 32'h104);
    check("fetch after store inst",     d, 32'h0010_0893);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
